// File: rtl/seq_pkg.sv
// Shared constants for the bus computer control sequencer: control word
// bit map, opcodes, FSM states and microstep limits.
package seq_pkg;

    localparam int OPCODE_W  = 4;
    localparam int STEP_W    = 3;
    localparam int MAX_STEPS = 5;
    localparam int CTRL_W    = 18;

    localparam int CTRL_HLT       = 0;
    localparam int CTRL_MAR_IN    = 1;
    localparam int CTRL_RAM_IN    = 2;
    localparam int CTRL_RAM_OUT   = 3;
    localparam int CTRL_IR_OUT    = 4;
    localparam int CTRL_IR_IN     = 5;
    localparam int CTRL_R1_IN     = 6;
    localparam int CTRL_R1_OUT    = 7;
    localparam int CTRL_ALU_OUT   = 8;
    localparam int CTRL_ALU_SUB   = 9;
    localparam int CTRL_R2_IN     = 10;
    localparam int CTRL_OUT_IN    = 11;
    localparam int CTRL_PC_INC    = 12;
    localparam int CTRL_PC_OUT    = 13;
    localparam int CTRL_PC_LOAD   = 14;
    localparam int CTRL_FLAGS_IN  = 15;
    localparam int CTRL_R1_CLR    = 16;
    localparam int CTRL_R2_CLR    = 17;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } state_e;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: one control word per (opcode, step),
// plus a flag marking the final microstep of the instruction.
module microcode_rom
    import seq_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                last
);

    logic [CTRL_W-1:0] fetch0;
    logic [CTRL_W-1:0] fetch1;
    logic [CTRL_W-1:0] addr_ir;
    logic [CTRL_W-1:0] jump;

    assign fetch0  = cbit(CTRL_PC_OUT) | cbit(CTRL_MAR_IN);
    assign fetch1  = cbit(CTRL_RAM_OUT) | cbit(CTRL_IR_IN)
                   | cbit(CTRL_PC_INC);
    assign addr_ir = cbit(CTRL_IR_OUT) | cbit(CTRL_MAR_IN);
    assign jump    = cbit(CTRL_IR_OUT) | cbit(CTRL_PC_LOAD);

    always_comb begin
        ctrl = '0;
        last = 1'b0;
        case (step)
            3'd0: ctrl = fetch0;
            3'd1: begin
                ctrl = fetch1;
                // Anything without a T2 action ends here (NOP, undefined)
                unique case (1'b1)
                    opcode == OP_LDA,
                    opcode == OP_ADD,
                    opcode == OP_SUB,
                    opcode == OP_STA,
                    opcode == OP_LDI,
                    opcode == OP_JMP,
                    opcode == OP_JC,
                    opcode == OP_JZ,
                    opcode == OP_OUT,
                    opcode == OP_HLT: last = 1'b0;
                    default:          last = 1'b1;
                endcase
            end
            3'd2: begin
                unique case (1'b1)
                    opcode == OP_LDA,
                    opcode == OP_ADD,
                    opcode == OP_SUB,
                    opcode == OP_STA: ctrl = addr_ir;
                    opcode == OP_LDI: begin
                        ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_R1_IN);
                        last = 1'b1;
                    end
                    opcode == OP_JMP: begin
                        ctrl = jump;
                        last = 1'b1;
                    end
                    opcode == OP_JC: begin
                        ctrl = flag_c ? jump : '0;
                        last = 1'b1;
                    end
                    opcode == OP_JZ: begin
                        ctrl = flag_z ? jump : '0;
                        last = 1'b1;
                    end
                    opcode == OP_OUT: begin
                        ctrl = cbit(CTRL_R1_OUT) | cbit(CTRL_OUT_IN);
                        last = 1'b1;
                    end
                    opcode == OP_HLT: begin
                        ctrl = cbit(CTRL_HLT);
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            3'd3: begin
                unique case (1'b1)
                    opcode == OP_LDA: begin
                        ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_R1_IN);
                        last = 1'b1;
                    end
                    opcode == OP_ADD,
                    opcode == OP_SUB:
                        ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_R2_IN);
                    opcode == OP_STA: begin
                        ctrl = cbit(CTRL_R1_OUT) | cbit(CTRL_RAM_IN);
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            3'd4: begin
                last = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_R1_IN)
                         | cbit(CTRL_FLAGS_IN);
                    if (opcode == OP_SUB) begin
                        ctrl = ctrl | cbit(CTRL_ALU_SUB);
                    end
                end
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded fetch/execute sequencer for the 8-bit bus computer.
// Optional SEQ_SINGLE_STEP_EN adds a step_req input for manual stepping.
module control_sequencer
    import seq_pkg::*;
(
    input  logic                clk,
    input  logic                clr_n,
    input  logic                run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step_req,
`endif
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CTRL_W-1:0]   ctrl_word,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic [CTRL_W-1:0] ctrl_d;
    logic              adv;
    logic              gate;

`ifdef SEQ_SINGLE_STEP_EN
    assign adv  = run & step_req;
    assign gate = step_req;
`else
    assign adv  = run;
    assign gate = 1'b1;
`endif

    microcode_rom u_rom (
        .opcode (opcode),
        .step   (step_q),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (rom_ctrl),
        .last   (rom_last)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ctrl_d  = '0;
        case (state_q)
            ST_INIT: begin
                ctrl_d = cbit(CTRL_R1_CLR) | cbit(CTRL_R2_CLR);
                if (adv) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                ctrl_d = rom_ctrl;
                if (adv) begin
                    if (rom_last || step_q >= STEP_W'(MAX_STEPS - 1)) begin
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                    if (rom_ctrl[CTRL_HLT]) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: step_d = '0;
            default: begin
                state_d = ST_INIT;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_INIT;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Reset, freeze and single-step gaps all blank the strobes
    assign ctrl_word = (clr_n && run && gate) ? ctrl_d : '0;
    assign step      = step_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus computer.
- Sits directly upstream of the bus registers. Drives their data_in, data_out and clr strobes, plus the PC, MAR, RAM, IR, ALU and output-register strobes.
- Steps through a fetch/execute microstep counter and decodes the 4-bit opcode held in IR into one control word per clock.

Parameters:
- OPCODE_W, 4, opcode width taken from the IR high nibble.
- STEP_W, 3, microstep counter width.
- MAX_STEPS, 5, microsteps per instruction (T0..T4).
- CTRL_W, 18, control word width (bit map in package).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clr_n  input  1  asynchronous active-low reset.
- run  input  1  1 = sequencer advances; 0 = freeze.
- opcode  input  OPCODE_W  IR[7:4]; valid from T2.
- flag_c  input  1  registered ALU carry flag.
- flag_z  input  1  registered ALU zero flag.
- ctrl_word  output  CTRL_W  control strobes for the current microstep.
- step  output  STEP_W  current microstep index.
- halted  output  1  high while in HALT.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, clr_n). While clr_n=0: state=INIT, step=0, halted=0, ctrl_word=0.
- Control word bit map: 0 hlt, 1 mar_in, 2 ram_in, 3 ram_out, 4 ir_out, 5 ir_in, 6 reg1_data_in, 7 reg1_data_out, 8 alu_out, 9 alu_sub, 10 reg2_data_in, 11 out_in, 12 pc_inc, 13 pc_out, 14 pc_load, 15 flags_in, 16 reg1_clr, 17 reg2_clr.
- Moore outputs: ctrl_word is a combinational decode of registered state/step/opcode/flags. Receivers latch on the same posedge.
- States: INIT -> RUN -> HALT.
  - INIT: exactly one cycle (when run=1) asserting reg1_clr and reg2_clr, then RUN with step=0.
  - HALT: sticky until clr_n.
- RUN microcode:
  - Common to all opcodes: T0 = pc_out|mar_in; T1 = ram_out|ir_in|pc_inc.
  - NOP 0000: length 2.
  - LDA 0001: T2 ir_out|mar_in; T3 ram_out|reg1_data_in; length 4.
  - ADD 0010: T2 ir_out|mar_in; T3 ram_out|reg2_data_in; T4 alu_out|reg1_data_in|flags_in; length 5.
  - SUB 0011: as ADD, with alu_sub added in T4.
  - STA 0100: T2 ir_out|mar_in; T3 reg1_data_out|ram_in; length 4.
  - LDI 0101: T2 ir_out|reg1_data_in; length 3.
  - JMP 0110: T2 ir_out|pc_load; length 3.
  - JC 0111: T2 ir_out|pc_load if flag_c=1, else all-zero; length 3 either way.
  - JZ 1000: same as JC, using flag_z.
  - OUT 1110: T2 reg1_data_out|out_in; length 3.
  - HLT 1111: T2 hlt; next state HALT.
  - Undefined opcodes 1001-1101: treated as NOP.
- Step advance: on the last microstep of an instruction, step wraps to 0 on the next edge (early termination, no dead cycles). Otherwise step increments. step never exceeds MAX_STEPS-1.
- Flags are sampled combinationally during T2 only.
- HALT: ctrl_word=0, halted=1, step=0.
- run=0: state and step hold, ctrl_word forced to 0. Deasserting run mid-instruction resumes at the same step.
- Invariants:
  - At most one of ram_out, ir_out, reg1_data_out, alu_out, pc_out is asserted in any cycle (single bus driver).
  - reg2_data_out is never asserted.
- Reset mid-instruction: immediate return to INIT. No partial strobes are emitted after clr_n falls.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step_req (1 bit).
  - Sequencer advances only on cycles where run=1 and step_req=1 (one microstep per pulse).
  - ctrl_word is gated to 0 on cycles where step_req=0, so receivers latch once per step.
- Undefined: step_req is absent; sequencer advances every cycle while run=1.

Decomposition:
- Package seq_pkg:
  - CTRL_* bit-index constants and CTRL_W.
  - OP_* opcode constants.
  - State enum (INIT, RUN, HALT).
  - MAX_STEPS.
- Sub-module microcode_rom: combinational; inputs (opcode, step, flag_c, flag_z); outputs (ctrl, last).
- control_sequencer owns the state register, step counter, run/step gating and the INIT/HALT overrides.

Test Plan:
- Reset then run=1 -> cycle 0 ctrl_word has only bits 16,17 set; then T0 = 0x2002 and T1 = 0x1028.
- opcode=0010 (ADD) -> T2 0x0012, T3 0x0408, T4 0x8140, then step=0; total 5 cycles.
- opcode=0111 (JC) with flag_c=0 -> T2 ctrl_word=0, step wraps after 3 cycles. With flag_c=1 -> T2 0x4010.
- opcode=1111 (HLT) -> T2 0x0001, then halted=1 and ctrl_word=0 for 20 cycles. clr_n pulse -> INIT.
- run dropped at T3 of LDA for 4 cycles -> ctrl_word=0 and step=3 held; on resume T3 = 0x0048.
- Random opcode/flag stream for 1000 cycles -> assertion: at most one bus driver per cycle, reg2_data_out always 0.
